// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 128-bit SRAM slave model, register-array store, independent read and write FSMs.
// Optional build macro AXI_SRAM_STALL_EN adds LFSR-driven backpressure on arready/awready/wready.
module axi_sram_slave #(
  parameter int          AXI_DATA_WIDTH = 128,
  parameter int          MEM_AW         = 10,
  parameter logic [15:0] STALL_SEED     = 16'hACE1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [3:0]                  arid,
  input  logic [31:0]                 araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [3:0]                  rid,
  output logic [AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  input  logic [3:0]                  awid,
  input  logic [31:0]                 awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [3:0]                  wid,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [3:0]                  bid,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << MEM_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {R_IDLE, R_BURST} rState_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [1:0] addrCheck(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] hiBits;
    hiBits = addr >> (MEM_AW + 4);
    if (hiBits != 32'd0) return RESP_DECERR;
    if (burst == 2'b11 || size != 3'b100) return RESP_SLVERR;
    if (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // WRAP lengths are 2^n-1, so len itself is the mask of index bits that wrap.
  function automatic logic [MEM_AW-1:0] nextIdx(input logic [MEM_AW-1:0] idx, input logic [7:0] len,
                                                input logic [1:0] burst);
    logic [MEM_AW-1:0] mask;
    logic [MEM_AW-1:0] inc;
    mask = MEM_AW'(len);
    inc  = idx + MEM_AW'(1);
    case (burst)
      BURST_FIXED: return idx;
      BURST_WRAP:  return (idx & ~mask) | (inc & mask);
      default:     return inc;
    endcase
  endfunction

  logic stallAr, stallAw, stallW;

`ifdef AXI_SRAM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= STALL_SEED;
    else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stallAr = lfsr_q[0];
  assign stallAw = lfsr_q[1];
  assign stallW  = lfsr_q[2];
`else
  assign stallAr = 1'b1;
  assign stallAw = 1'b1;
  assign stallW  = 1'b1;
`endif

  logic unusedBits;
  assign unusedBits = ^{wid, araddr[3:0], awaddr[3:0], STALL_SEED};

  rState_e                   rState_q, rState_d;
  logic [3:0]                rid_q, rid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rlast_q, rlast_d;
  logic                      rvalid_q, rvalid_d;
  logic [7:0]                rLen_q, rLen_d;
  logic [7:0]                rCnt_q, rCnt_d;
  logic [1:0]                rBurst_q, rBurst_d;
  logic [MEM_AW-1:0]         rIdx_q, rIdx_d;
  logic [MEM_AW-1:0]         arIdx;
  logic [1:0]                arResp;
  logic                      arFire, rFire;

  assign arIdx   = araddr[MEM_AW+3:4];
  assign arResp  = addrCheck(araddr, arlen, arsize, arburst);
  assign arready = (rState_q == R_IDLE) && stallAr;
  assign arFire  = arvalid && arready;
  assign rFire   = rvalid_q && rready;

  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;
  assign rvalid = rvalid_q;

  // Every accepted beat preloads the next one, so R streams at full rate while rready holds.
  always_comb begin
    rState_d = rState_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rvalid_d = rvalid_q;
    rLen_d   = rLen_q;
    rCnt_d   = rCnt_q;
    rBurst_d = rBurst_q;
    rIdx_d   = rIdx_q;
    case (rState_q)
      R_IDLE: begin
        if (arFire) begin
          rState_d = R_BURST;
          rid_d    = arid;
          rLen_d   = arlen;
          rBurst_d = arburst;
          rresp_d  = arResp;
          rCnt_d   = 8'd0;
          rdata_d  = (arResp == RESP_OKAY) ? mem[arIdx] : '0;
          rIdx_d   = nextIdx(arIdx, arlen, arburst);
          rlast_d  = (arlen == 8'd0);
          rvalid_d = 1'b1;
        end
      end
      R_BURST: begin
        if (rFire) begin
          if (rlast_q) begin
            rState_d = R_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            rCnt_d  = rCnt_q + 8'd1;
            rdata_d = (rresp_q == RESP_OKAY) ? mem[rIdx_q] : '0;
            rIdx_d  = nextIdx(rIdx_q, rLen_q, rBurst_q);
            rlast_d = (rCnt_d == rLen_q);
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rState_q <= R_IDLE;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rLen_q   <= '0;
      rCnt_q   <= '0;
      rBurst_q <= '0;
      rIdx_q   <= '0;
    end else begin
      rState_q <= rState_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
      rLen_q   <= rLen_d;
      rCnt_q   <= rCnt_d;
      rBurst_q <= rBurst_d;
      rIdx_q   <= rIdx_d;
    end
  end

  wState_e           wState_q, wState_d;
  logic [3:0]        bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [7:0]        wLen_q, wLen_d;
  logic [1:0]        wBurst_q, wBurst_d;
  logic [MEM_AW-1:0] wIdx_q, wIdx_d;
  logic [8:0]        wCnt_q, wCnt_d;
  logic              awFire, wFire, bFire, beatInRange, memWe;

  assign awready     = (wState_q == W_IDLE) && stallAw;
  assign wready      = (wState_q == W_DATA) && stallW;
  assign bvalid      = (wState_q == W_RESP);
  assign bid         = bid_q;
  assign bresp       = bresp_q;
  assign awFire      = awvalid && awready;
  assign wFire       = wvalid && wready;
  assign bFire       = bvalid && bready;
  assign beatInRange = (wCnt_q <= {1'b0, wLen_q});
  assign memWe       = wFire && beatInRange && (bresp_q == RESP_OKAY);

  // The beat counter stops at len+1, so surplus beats stay out of range and cannot wrap it.
  always_comb begin
    wState_d = wState_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    wLen_d   = wLen_q;
    wBurst_d = wBurst_q;
    wIdx_d   = wIdx_q;
    wCnt_d   = wCnt_q;
    case (wState_q)
      W_IDLE: begin
        if (awFire) begin
          wState_d = W_DATA;
          bid_d    = awid;
          bresp_d  = addrCheck(awaddr, awlen, awsize, awburst);
          wLen_d   = awlen;
          wBurst_d = awburst;
          wIdx_d   = awaddr[MEM_AW+3:4];
          wCnt_d   = 9'd0;
        end
      end
      W_DATA: begin
        if (wFire) begin
          if (beatInRange) begin
            wCnt_d = wCnt_q + 9'd1;
            wIdx_d = nextIdx(wIdx_q, wLen_q, wBurst_q);
          end
          if ((!beatInRange || (wlast && wCnt_q != {1'b0, wLen_q})) && bresp_q == RESP_OKAY)
            bresp_d = RESP_SLVERR;
          if (wlast) wState_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bFire) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wState_q <= W_IDLE;
      bid_q    <= '0;
      bresp_q  <= '0;
      wLen_q   <= '0;
      wBurst_q <= '0;
      wIdx_q   <= '0;
      wCnt_q   <= '0;
    end else begin
      wState_q <= wState_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      wLen_q   <= wLen_d;
      wBurst_q <= wBurst_d;
      wIdx_q   <= wIdx_d;
      wCnt_q   <= wCnt_d;
    end
  end

  // Storage is deliberately not reset; a same-edge read sees the pre-write word.
  always_ff @(posedge aclk) begin
    if (memWe) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[wIdx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed AXI bursts against axi_sram_slave; expected R/B responses are queued
// by the stimulus and popped by an independent monitor.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  localparam int TIMEOUT = 2000;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [3:0]   arid = '0;
  logic [31:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic [2:0]   arsize = 3'b100;
  logic [1:0]   arburst = INCR;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [3:0]   awid = '0;
  logic [31:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic [2:0]   awsize = 3'b100;
  logic [1:0]   awburst = INCR;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [3:0]   wid = '0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic         wlast = 1'b0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;

  axi_sram_slave #(.AXI_DATA_WIDTH(128), .MEM_AW(10), .STALL_SEED(16'hACE1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]   id;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } rExp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bExp_t;

  rExp_t        rExpQ[$];
  bExp_t        bExpQ[$];
  int           vectors = 0;
  int           errors = 0;
  bit           rvPend = 1'b0;
  bit           bvPend = 1'b0;
  bit           stallDone = 1'b0;
  logic [127:0] wBeats[64];
  logic [127:0] expBeats[64];
  logic [127:0] wrapD[4];

  // Preload pattern: word w holds four copies of C0DE_00ww.
  function automatic logic [127:0] pat(input int w);
    logic [31:0] v;
    v = 32'hC0DE_0000 + 32'(w);
    return {4{v}};
  endfunction

  function automatic logic [63:0] patHi(input int w);
    logic [31:0] v;
    v = 32'hC0DE_0000 + 32'(w);
    return {2{v}};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    errors++;
    $display("[TB] FAIL %s: no handshake within %0d cycles, required one", name, TIMEOUT);
  endtask

  task automatic pushR(input logic [3:0] id, input logic [127:0] data, input logic [1:0] resp, input logic last);
    rExp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    rExpQ.push_back(e);
  endtask

  task automatic pushB(input logic [3:0] id, input logic [1:0] resp);
    bExp_t e;
    e.id = id; e.resp = resp;
    bExpQ.push_back(e);
  endtask

  // Monitor: pops an expectation for every R or B handshake and watches for withdrawn valids.
  always @(negedge aclk) begin : monitor
    rExp_t re;
    bExp_t be;
    if (!aresetn) begin
      rvPend = 1'b0;
      bvPend = 1'b0;
    end else begin
      if (rvPend) checkOutput("rvalidHeld", 128'(rvalid), 128'd1);
      if (bvPend) checkOutput("bvalidHeld", 128'(bvalid), 128'd1);
      if (rvalid && rready) begin
        if (rExpQ.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL rUnexpected: got beat rid=%h rdata=%h, required no beat", rid, rdata);
        end else begin
          re = rExpQ.pop_front();
          checkOutput("rid", 128'(rid), 128'(re.id));
          checkOutput("rdata", rdata, re.data);
          checkOutput("rresp", 128'(rresp), 128'(re.resp));
          checkOutput("rlast", 128'(rlast), 128'(re.last));
        end
      end
      if (bvalid && bready) begin
        if (bExpQ.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL bUnexpected: got bid=%h bresp=%h, required no response", bid, bresp);
        end else begin
          be = bExpQ.pop_front();
          checkOutput("bid", 128'(bid), 128'(be.id));
          checkOutput("bresp", 128'(bresp), 128'(be.resp));
        end
      end
      rvPend = rvalid && !rready;
      bvPend = bvalid && !bready;
    end
  end

  // All phase tasks are entered and left 1ns after a rising edge.
  task automatic arPhase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = 3'b100; arburst = burst; arvalid = 1'b1;
    do begin
      @(negedge aclk);
      n++;
    end while (!arready && n < TIMEOUT);
    if (!arready) timeoutFail("arHandshake");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    checkOutput("rvalidLatency", 128'(rvalid), 128'd1);
  endtask

  task automatic awPhase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    do begin
      @(negedge aclk);
      n++;
    end while (!awready && n < TIMEOUT);
    if (!awready) timeoutFail("awHandshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic wPhase(input int nBeats, input int lastBeat, input logic [15:0] strb);
    for (int i = 0; i < nBeats; i++) begin
      int n = 0;
      wdata = wBeats[i]; wstrb = strb; wlast = (i == lastBeat); wvalid = 1'b1;
      do begin
        @(negedge aclk);
        n++;
      end while (!wready && n < TIMEOUT);
      if (!wready) timeoutFail("wHandshake");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic waitDrain(output int cycles);
    cycles = 0;
    while ((rExpQ.size() != 0 || bExpQ.size() != 0) && cycles < TIMEOUT) begin
      @(negedge aclk); #1;
      cycles++;
    end
    if (rExpQ.size() != 0 || bExpQ.size() != 0) timeoutFail("drain");
    @(posedge aclk); #1;
  endtask

  task automatic axiRead(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [1:0] resp);
    int cyc;
    for (int i = 0; i <= int'(len); i++)
      pushR(id, (resp == OKAY) ? expBeats[i] : 128'd0, resp, i == int'(len));
    arPhase(id, addr, len, burst);
    waitDrain(cyc);
`ifndef AXI_SRAM_STALL_EN
    if (rready) checkOutput("rBurstCycles", 128'(cyc), 128'(int'(len) + 1));
`endif
  endtask

  task automatic axiWrite(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nBeats,
                          input int lastBeat, input logic [15:0] strb, input logic [1:0] resp,
                          input bit holdB);
    int cyc;
    pushB(id, resp);
    if (holdB) bready = 1'b0;
    awPhase(id, addr, len, size, burst);
    wPhase(nBeats, lastBeat, strb);
    if (holdB) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge aclk);
        checkOutput("bvalidStall", 128'(bvalid), 128'd1);
      end
      @(posedge aclk); #1;
      bready = 1'b1;
    end
    waitDrain(cyc);
  endtask

  task automatic applyStimulus();
    int cyc;

    // Preload words 0..7 and read back the middle four.
    for (int i = 0; i < 8; i++) wBeats[i] = pat(i);
    axiWrite(4'h1, 32'h0000_0000, 8'd7, 3'b100, INCR, 8, 7, 16'hFFFF, OKAY, 1'b0);
    for (int i = 0; i < 4; i++) expBeats[i] = pat(4 + i);
    axiRead(4'h5, 32'h0000_0040, 8'd3, INCR, OKAY);

    // WRAP write starting at word 3 lands on 3,0,1,2 and touches only the low 8 bytes.
    wrapD[0] = 128'hAAAA_0000_AAAA_0001_AAAA_0002_AAAA_0003;
    wrapD[1] = 128'hBBBB_0000_BBBB_0001_BBBB_0002_BBBB_0003;
    wrapD[2] = 128'hCCCC_0000_CCCC_0001_CCCC_0002_CCCC_0003;
    wrapD[3] = 128'hDDDD_0000_DDDD_0001_DDDD_0002_DDDD_0003;
    for (int i = 0; i < 4; i++) wBeats[i] = wrapD[i];
    axiWrite(4'h6, 32'h0000_0030, 8'd3, 3'b100, WRAP, 4, 3, 16'h00FF, OKAY, 1'b1);
    expBeats[0] = {patHi(0), wrapD[1][63:0]};
    expBeats[1] = {patHi(1), wrapD[2][63:0]};
    expBeats[2] = {patHi(2), wrapD[3][63:0]};
    expBeats[3] = {patHi(3), wrapD[0][63:0]};
    axiRead(4'h7, 32'h0000_0000, 8'd3, INCR, OKAY);

    // Error responses: out of window, bad size, bad WRAP length; plus a FIXED burst.
    axiRead(4'h2, 32'h0001_0000, 8'd1, INCR, DECERR);
    wBeats[0] = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    axiWrite(4'h4, 32'h0000_0020, 8'd0, 3'b010, INCR, 1, 0, 16'hFFFF, SLVERR, 1'b0);
    expBeats[0] = {patHi(2), wrapD[3][63:0]};
    axiRead(4'h3, 32'h0000_0020, 8'd0, INCR, OKAY);
    axiRead(4'h8, 32'h0000_0040, 8'd2, WRAP, SLVERR);
    for (int i = 0; i < 3; i++) expBeats[i] = pat(5);
    axiRead(4'h9, 32'h0000_0050, 8'd2, FIXED, OKAY);

    // Early and late wlast.
    for (int i = 0; i < 8; i++) wBeats[i] = pat(16 + i);
    axiWrite(4'h1, 32'h0000_0100, 8'd7, 3'b100, INCR, 8, 7, 16'hFFFF, OKAY, 1'b0);
    wBeats[0] = 128'hEEEE_EEEE_1111_1111_EEEE_EEEE_1111_1111;
    axiWrite(4'hA, 32'h0000_0100, 8'd1, 3'b100, INCR, 1, 0, 16'hFFFF, SLVERR, 1'b0);
    expBeats[0] = 128'hEEEE_EEEE_1111_1111_EEEE_EEEE_1111_1111;
    expBeats[1] = pat(17);
    axiRead(4'hA, 32'h0000_0100, 8'd1, INCR, OKAY);
    wBeats[0] = 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
    wBeats[1] = 128'hF1F1_F1F1_F1F1_F1F1_F1F1_F1F1_F1F1_F1F1;
    wBeats[2] = 128'hF2F2_F2F2_F2F2_F2F2_F2F2_F2F2_F2F2_F2F2;
    axiWrite(4'hB, 32'h0000_0140, 8'd0, 3'b100, INCR, 3, 2, 16'hFFFF, SLVERR, 1'b0);
    expBeats[0] = 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
    expBeats[1] = pat(21);
    axiRead(4'hB, 32'h0000_0140, 8'd1, INCR, OKAY);

`ifndef AXI_SRAM_STALL_EN
    // Same-edge read and write of word 8: read sees the old value.
    wBeats[0] = pat(8);
    axiWrite(4'h1, 32'h0000_0080, 8'd0, 3'b100, INCR, 1, 0, 16'hFFFF, OKAY, 1'b0);
    pushB(4'hC, OKAY);
    pushR(4'hD, pat(8), OKAY, 1'b1);
    awPhase(4'hC, 32'h0000_0080, 8'd0, 3'b100, INCR);
    wBeats[0] = 128'h8888_0000_8888_0001_8888_0002_8888_0003;
    fork
      arPhase(4'hD, 32'h0000_0080, 8'd0, INCR);
      wPhase(1, 0, 16'hFFFF);
    join
    waitDrain(cyc);
    expBeats[0] = 128'h8888_0000_8888_0001_8888_0002_8888_0003;
    axiRead(4'hD, 32'h0000_0080, 8'd0, INCR, OKAY);
`endif

    // Reset in the middle of a read burst.
    rready = 1'b0;
    arPhase(4'h6, 32'h0000_0000, 8'd7, INCR);
    @(negedge aclk); #2;
    aresetn = 1'b0;
    #1;
    checkOutput("rvalidAsyncReset", 128'(rvalid), 128'd0);
    checkOutput("rlastAsyncReset", 128'(rlast), 128'd0);
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b1;
    rready = 1'b1;
    @(posedge aclk); #1;
    checkOutput("arreadyAfterReset", 128'(arready), 128'd1);
    expBeats[0] = pat(4);
    axiRead(4'h2, 32'h0000_0040, 8'd0, INCR, OKAY);

`ifdef AXI_SRAM_STALL_EN
    // Long burst under backpressure with random rready.
    for (int i = 0; i < 64; i++) wBeats[i] = pat(32 + i);
    axiWrite(4'hE, 32'h0000_0200, 8'd63, 3'b100, INCR, 64, 63, 16'hFFFF, OKAY, 1'b0);
    for (int i = 0; i < 64; i++) expBeats[i] = pat(32 + i);
    stallDone = 1'b0;
    fork
      begin
        axiRead(4'hE, 32'h0000_0200, 8'd63, INCR, OKAY);
        stallDone = 1'b1;
      end
      begin
        while (!stallDone) begin
          @(posedge aclk); #1;
          if (!stallDone) rready = 1'($urandom_range(0, 1));
        end
      end
    join
    rready = 1'b1;
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500us, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("resetArready", 128'(arready), 128'd1);
`ifdef AXI_SRAM_STALL_EN
    checkOutput("resetAwready", 128'(awready), 128'd0);
`else
    checkOutput("resetAwready", 128'(awready), 128'd1);
`endif
    checkOutput("resetRvalid", 128'(rvalid), 128'd0);
    checkOutput("resetRlast", 128'(rlast), 128'd0);
    checkOutput("resetBvalid", 128'(bvalid), 128'd0);
    checkOutput("resetWready", 128'(wready), 128'd0);
    checkOutput("resetRid", 128'(rid), 128'd0);
    checkOutput("resetRdata", rdata, 128'd0);
    checkOutput("resetRresp", 128'(rresp), 128'd0);
    checkOutput("resetBid", 128'(bid), 128'd0);
    checkOutput("resetBresp", 128'(bresp), 128'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    $display("[TB] reset released, starting directed bursts");
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave memory model on the 128-bit bus driven by the CPU core's AXI master; it sits directly downstream of the CPU top level in simulation and on FPGA bring-up.
- Register-array backing store with independent read and write FSMs, so one read burst and one write burst can be active at once.
- Supports FIXED, INCR and WRAP bursts and returns OKAY, SLVERR or DECERR responses.

Parameters:
AXI_DATA_WIDTH, 128, data bus width; only 128 is supported; beat = 16 bytes.
MEM_AW, 10, log2 of memory depth in 128-bit words; window = 2^(MEM_AW+4) bytes starting at 0.
STALL_SEED, 16'hACE1, LFSR reset value; used only under AXI_SRAM_STALL_EN.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  4  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  beat size
arburst  in  2  burst type
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  read ID echo
rdata  out  128  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  4  write ID
awaddr  in  32  write byte address
awlen  in  8  beats-1
awsize  in  3  beat size
awburst  in  2  burst type
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  write-data ID (ignored)
wdata  in  128  write data
wstrb  in  16  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  write ID echo
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (aresetn=0, asynchronous): both FSMs go to IDLE. arready=1, awready=1. rvalid, rlast, bvalid, wready = 0. rid, rdata, rresp, bid, bresp = 0. Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. No response is issued; partially written beats stay written.
- Word index = addr[MEM_AW+3:4]. Low 4 address bits are ignored. An address is out of window if any of addr[31:MEM_AW+4] is nonzero.
- Error priority, evaluated at the address handshake:
  - Out of window -> DECERR (2'b11).
  - Else burst type 2'b11, size != 3'b100, or WRAP with len not in {1,3,7,15} -> SLVERR (2'b10).
  - Else OKAY.
- Next-index rule:
  - FIXED: index held.
  - INCR: index+1, modulo 2^MEM_AW.
  - WRAP: low log2(len+1) bits increment and wrap; upper bits held.
- Read FSM, R_IDLE -> R_BURST:
  - In R_IDLE: arready=1. The AR handshake latches id, len, burst, resp and the next index, and loads rdata=mem[index] on the same edge (combinational array read).
  - rvalid=1 from the next cycle: one-cycle latency.
  - In R_BURST: arready=0. rvalid stays high until the final handshake. rlast=1 when beat count == len.
  - Each handshake loads the next beat, so bursts run back-to-back while rready stays high.
  - Error bursts return all len+1 beats with rdata=0 and the error response.
  - After the rlast handshake: rvalid=0, return to R_IDLE, arready=1 on the next cycle.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - In W_IDLE: awready=1. The AW handshake latches id, len, burst and the error state. wready=1 from the next cycle.
  - In W_DATA: each W handshake writes the bytes of mem[index] enabled by wstrb, unless the burst carries an error, then advances the index.
  - Beats beyond len+1 are dropped and force SLVERR.
  - wlast on the handshake -> W_RESP, wready=0. wlast arriving with beat count != len forces SLVERR. Only wlast ends the phase.
  - In W_RESP: bvalid=1 and bid=latched id, held until bready; then return to W_IDLE.
- Simultaneous read and write to the same word on the same edge: the read gets the old data; the write lands.
- Both address channels are accepted in the same cycle independently.

Optional Feature:
- AXI_SRAM_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) resets to STALL_SEED and advances every cycle.
  - arready, awready and wready are ANDed with lfsr[0], lfsr[1] and lfsr[2] respectively.
  - rvalid and bvalid are never withdrawn once asserted.
- Macro undefined: no LFSR; readies follow the FSM directly.

Test Plan:
- INCR read, araddr=0x40, arlen=3, rready=1, after preloading mem[4..7] -> rvalid the cycle after the handshake, 4 consecutive beats of words 4..7, rlast on beat 4, rresp=0, rid echoed.
- WRAP write, awaddr=0x30, awlen=3, wstrb=16'h00FF, data A,B,C,D -> low 8 bytes of words 3,0,1,2 updated and upper bytes unchanged; bresp=0 after wlast; bvalid held through 3 cycles of bready=0.
- Read araddr=0x0001_0000 (MEM_AW=10), arlen=1 -> 2 beats, rdata=0, rresp=2'b11; then write awsize=3'b010 -> memory unchanged, bresp=2'b10.
- Write awlen=1 with wlast on beat 1 -> bresp=2'b10 and only word 0 written. Write awlen=0 with 3 beats, wlast on the third -> bresp=2'b10 and only one word written.
- Concurrent read of word 8 and write of word 8 on the same edge -> read returns the old value; a second read returns the new value. Deassert aresetn mid read burst -> rvalid=0 asynchronously and arready=1 after release.
- With AXI_SRAM_STALL_EN: 64-beat INCR write then read back with random rready -> data matches and no rvalid or bvalid drop before its handshake.
